// File: rtl/lpc_pkg.sv
// lpc_pkg: shared definitions for the LPC host initiator.
//   - CT/DIR nibble values for I/O and memory cycles
//   - SYNC codes driven by the peripheral
//   - FSM state and response status enumerations
//   - helpers: request validation, SIZE nibble encoding, write-data nibble order
package lpc_pkg;

  localparam logic [3:0] CTDIR_IO_RD  = 4'b0000;
  localparam logic [3:0] CTDIR_IO_WR  = 4'b0010;
  localparam logic [3:0] CTDIR_MEM_RD = 4'b0100;
  localparam logic [3:0] CTDIR_MEM_WR = 4'b0110;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;
  localparam logic [3:0] SYNC_NONE  = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CTDIR,
    ST_SIZE,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_RDATA,
    ST_PTAR1,
    ST_PTAR2,
    ST_ABORT,
    ST_DONE
  } lpc_state_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_SYNC_ERR = 2'd1,
    STAT_ABORT    = 2'd2,
    STAT_BAD_REQ  = 2'd3
  } lpc_status_e;

  // Cycle type lives in bits 3:2 (00 I/O, 01 memory); bit 1 is direction,
  // bit 0 is reserved and passed through untouched.
  function automatic logic request_ok(input logic [3:0] ctdir, input logic [2:0] size);
    logic size_legal;
    size_legal = (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
    if (ctdir[3])
      request_ok = 1'b0;
    else if (ctdir[2])
      request_ok = size_legal;
    else
      request_ok = (size == 3'd1);
  endfunction

  function automatic logic [3:0] size_nibble(input logic [2:0] size);
    case (size)
      3'd2:    size_nibble = 4'b0001;
      3'd4:    size_nibble = 4'b0011;
      default: size_nibble = 4'b0000;
    endcase
  endfunction

  // Reorders write data so that the shifter, which emits from the MSB end,
  // produces byte 0 low nibble, byte 0 high nibble, byte 1 low nibble, ...
  function automatic logic [39:0] data_nibble_order(input logic [31:0] data);
    logic [39:0] seq;
    seq = '0;
    for (int unsigned k = 0; k < 8; k++)
      seq[39 - 4*k -: 4] = data[4*k +: 4];
    data_nibble_order = seq;
  endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// lpc_nibble_shift: load/shift register that presents address or data
// nibbles on LAD, most significant nibble first.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val / i_load_cnt (wins over shift)
//   i_load_val     : 40-bit value, first nibble in bits 39:36
//   i_load_cnt     : number of nibbles to emit
//   i_shift        : advance to the next nibble
//   o_nibble       : current nibble
//   o_last         : current nibble is the final one
module lpc_nibble_shift (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [39:0] i_load_val,
  input  logic [3:0]  i_load_cnt,
  input  logic        i_shift,
  output logic [3:0]  o_nibble,
  output logic        o_last
);

  logic [39:0] r_sr;
  logic [3:0]  r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_load_val;
      r_cnt <= i_load_cnt;
    end else if (i_shift && (r_cnt != 4'd0)) begin
      r_sr  <= {r_sr[35:0], 4'h0};
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_nibble = r_sr[39:36];
  assign o_last   = (r_cnt == 4'd1);

endmodule

// File: rtl/lpc_host.sv
// lpc_host: LPC bus initiator. Accepts one request at a time and runs a full
// LPC I/O or memory read/write cycle: START, CT/DIR, SIZE (memory), address,
// write data, TAR, SYNC (with wait states / abort), read data, TAR.
//   SYNC_TIMEOUT   : consecutive wait SYNCs (0101/0110) before abort
//   NO_DEV_CYCLES  : consecutive no-device SYNCs before abort
//   lpc_clock, lpc_reset (async, active low)
//   req_*          : request handshake and fields (latched on accept)
//   resp_*         : one-cycle completion pulse, data and status
//   lpc_frame      : LFRAME#, active low
//   lpc_ad_out/oe  : LAD drive; lpc_ad_in : sampled LAD
module lpc_host
  import lpc_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT  = 32,
  parameter int unsigned NO_DEV_CYCLES = 3
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_data_size,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_status,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  localparam logic [15:0] LP_TIMEOUT = 16'(SYNC_TIMEOUT);
  localparam logic [15:0] LP_NODEV   = 16'(NO_DEV_CYCLES);

  lpc_state_e  r_state;
  lpc_state_e  w_state_next;
  lpc_status_e r_stat;

  logic [3:0]  r_ctdir;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_size;
  logic [15:0] r_wait;
  logic [15:0] r_nodev;
  logic [3:0]  r_rcnt;
  logic [1:0]  r_abort_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_resp_data;
  logic [1:0]  r_resp_status;

  logic        w_is_mem;
  logic        w_is_write;
  logic [3:0]  w_nib_total;
  logic        w_req_ok;
  logic        w_sync_wait;
  logic        w_sync_done;
  logic        w_timeout;
  logic        w_nodev_hit;
  logic        w_enter_done;

  logic        w_sh_load;
  logic [39:0] w_sh_val;
  logic [3:0]  w_sh_cnt;
  logic        w_sh_shift;
  logic [3:0]  w_sh_nibble;
  logic        w_sh_last;

  assign w_is_mem    = r_ctdir[2];
  assign w_is_write  = r_ctdir[1];
  assign w_nib_total = {r_size, 1'b0};
  assign w_req_ok    = request_ok(req_cyctype_dir, req_data_size);

  assign w_sync_wait = (lpc_ad_in == SYNC_SHORT) || (lpc_ad_in == SYNC_LONG);
  assign w_sync_done = (lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERROR);
  // Counters hold the count of earlier cycles, so the limit is reached on
  // the cycle where count+1 equals it.
  assign w_timeout   = w_sync_wait && ((r_wait + 16'd1) == LP_TIMEOUT);
  assign w_nodev_hit = !w_sync_wait && !w_sync_done && ((r_nodev + 16'd1) == LP_NODEV);

  // Address is loaded while START is on the bus; write data is reloaded on
  // the last address nibble so WDATA follows without a gap.
  assign w_sh_load  = (r_state == ST_START) ||
                      ((r_state == ST_ADDR) && w_sh_last && w_is_write);
  assign w_sh_val   = (r_state == ST_START) ?
                      (w_is_mem ? {r_addr, 8'h00} : {r_addr[15:0], 24'h000000}) :
                      data_nibble_order(r_data);
  assign w_sh_cnt   = (r_state == ST_START) ? (w_is_mem ? 4'd8 : 4'd4) : w_nib_total;
  assign w_sh_shift = (r_state == ST_ADDR) || (r_state == ST_WDATA);

  lpc_nibble_shift u_shift (
    .i_clk      (lpc_clock),
    .i_rst_n    (lpc_reset),
    .i_load     (w_sh_load),
    .i_load_val (w_sh_val),
    .i_load_cnt (w_sh_cnt),
    .i_shift    (w_sh_shift),
    .o_nibble   (w_sh_nibble),
    .o_last     (w_sh_last)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_next = w_req_ok ? ST_START : ST_DONE;
      ST_START: w_state_next = ST_CTDIR;
      ST_CTDIR: w_state_next = w_is_mem ? ST_SIZE : ST_ADDR;
      ST_SIZE:  w_state_next = ST_ADDR;
      ST_ADDR:  if (w_sh_last) w_state_next = w_is_write ? ST_WDATA : ST_TAR1;
      ST_WDATA: if (w_sh_last) w_state_next = ST_TAR1;
      ST_TAR1:  w_state_next = ST_TAR2;
      ST_TAR2:  w_state_next = ST_SYNC;
      ST_SYNC: begin
        if (w_sync_done)
          w_state_next = w_is_write ? ST_PTAR1 : ST_RDATA;
        else if (w_timeout || w_nodev_hit)
          w_state_next = ST_ABORT;
      end
      ST_RDATA: if (r_rcnt == (w_nib_total - 4'd1)) w_state_next = ST_PTAR1;
      ST_PTAR1: w_state_next = ST_PTAR2;
      ST_PTAR2: w_state_next = ST_DONE;
      ST_ABORT: if (r_abort_cnt == 2'd3) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      r_state       <= ST_IDLE;
      r_stat        <= STAT_OK;
      r_ctdir       <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_size        <= '0;
      r_wait        <= '0;
      r_nodev       <= '0;
      r_rcnt        <= '0;
      r_abort_cnt   <= '0;
      r_acc         <= '0;
      r_resp_data   <= '0;
      r_resp_status <= '0;
    end else begin
      r_state <= w_state_next;

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ctdir     <= req_cyctype_dir;
            r_addr      <= req_addr;
            r_data      <= req_data;
            r_size      <= req_data_size;
            r_stat      <= w_req_ok ? STAT_OK : STAT_BAD_REQ;
            r_wait      <= '0;
            r_nodev     <= '0;
            r_rcnt      <= '0;
            r_abort_cnt <= '0;
            r_acc       <= '0;
          end
        end
        ST_SYNC: begin
          if (lpc_ad_in == SYNC_ERROR) begin
            r_stat <= STAT_SYNC_ERR;
          end else if (w_sync_wait) begin
            r_wait  <= r_wait + 16'd1;
            r_nodev <= '0;
          end else if (lpc_ad_in != SYNC_READY) begin
            r_nodev <= r_nodev + 16'd1;
            r_wait  <= '0;
          end
        end
        ST_RDATA: begin
          r_acc[{r_rcnt[2:0], 2'b00} +: 4] <= lpc_ad_in;
          r_rcnt <= r_rcnt + 4'd1;
        end
        ST_ABORT: r_abort_cnt <= r_abort_cnt + 2'd1;
        default: ;
      endcase

      if ((w_state_next == ST_ABORT) && (r_state != ST_ABORT)) begin
        r_stat      <= STAT_ABORT;
        r_abort_cnt <= '0;
      end

      if (w_enter_done) begin
        if (r_state == ST_IDLE)
          r_resp_status <= STAT_BAD_REQ;
        else
          r_resp_status <= r_stat;
        r_resp_data <= ((r_state == ST_PTAR2) && !w_is_write) ? r_acc : '0;
      end
    end
  end

  always_comb begin
    lpc_frame  = 1'b1;
    lpc_ad_oe  = 1'b0;
    lpc_ad_out = SYNC_NONE;
    case (r_state)
      ST_START: begin
        lpc_frame  = 1'b0;
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = 4'b0000;
      end
      ST_CTDIR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = r_ctdir;
      end
      ST_SIZE: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = size_nibble(r_size);
      end
      ST_ADDR, ST_WDATA: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = w_sh_nibble;
      end
      ST_TAR1: lpc_ad_oe = 1'b1;
      ST_ABORT: begin
        lpc_frame = 1'b0;
        lpc_ad_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_DONE);
  assign resp_data   = r_resp_data;
  assign resp_status = r_resp_status;

endmodule

// File: tb/tb_lpc_host.sv
module tb_lpc_host;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_data_size = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in = 4'hF;

  always #5 lpc_clock = ~lpc_clock;

  lpc_host #(.SYNC_TIMEOUT(32), .NO_DEV_CYCLES(3)) dut (
    .lpc_clock       (lpc_clock),
    .lpc_reset       (lpc_reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cyctype_dir (req_cyctype_dir),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_data_size   (req_data_size),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_status     (resp_status),
    .lpc_frame       (lpc_frame),
    .lpc_ad_out      (lpc_ad_out),
    .lpc_ad_oe       (lpc_ad_oe),
    .lpc_ad_in       (lpc_ad_in)
  );

  int total = 0;
  int bad   = 0;

  // One bus cycle of the expected transaction: what the host drives, what the
  // peripheral answers on LAD, and whether this is the completion cycle.
  typedef struct packed {
    logic       frame;
    logic       oe;
    logic [3:0] ad;
    logic [3:0] din;
    logic       done;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [3:0]  sync_q[$];
  logic [31:0] exp_rdata;
  logic [1:0]  exp_status;
  logic [31:0] last_data;
  logic [1:0]  last_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic f, input logic o, input logic [3:0] a,
                              input logic [3:0] di, input logic dn);
    cyc_t c;
    c.frame = f; c.oe = o; c.ad = a; c.din = di; c.done = dn;
    return c;
  endfunction

  // Reference model: expands a request plus the peripheral's SYNC answers
  // into the per-cycle bus trace and final response.
  task automatic build(input logic [3:0] ct, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz, input logic [31:0] rd);
    int  n;
    int  waits;
    int  nodev;
    bit  mem, wr, ok, aborted, ended;
    logic [3:0]  c;
    logic [31:0] mask;
    exp_q.delete();
    n   = int'(sz);
    mem = (ct[3:2] == 2'b01);
    wr  = ct[1];
    ok  = (ct[3:2] == 2'b00 || mem) && (n == 1 || n == 2 || n == 4) && (mem || n == 1);
    exp_rdata = 32'h0;
    if (!ok) begin
      exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b1));
      exp_status = 2'd3;
      return;
    end
    exp_q.push_back(mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, ct, 4'hF, 1'b0));
    if (mem) exp_q.push_back(mk(1'b1, 1'b1, 4'(n - 1), 4'hF, 1'b0));
    for (int i = (mem ? 7 : 3); i >= 0; i--)
      exp_q.push_back(mk(1'b1, 1'b1, a[4*i +: 4], 4'hF, 1'b0));
    if (wr)
      for (int k = 0; k < 2*n; k++)
        exp_q.push_back(mk(1'b1, 1'b1, d[4*k +: 4], 4'hF, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 4'hF, 4'hF, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0));
    exp_status = 2'd0;
    waits = 0; nodev = 0; aborted = 0; ended = 0;
    foreach (sync_q[j]) begin
      if (!ended && !aborted) begin
        c = sync_q[j];
        exp_q.push_back(mk(1'b1, 1'b0, 4'h0, c, 1'b0));
        if (c == 4'h0) ended = 1;
        else if (c == 4'hA) begin ended = 1; exp_status = 2'd1; end
        else if (c == 4'h5 || c == 4'h6) begin
          waits++; nodev = 0;
          if (waits == 32) aborted = 1;
        end else begin
          nodev++; waits = 0;
          if (nodev == 3) aborted = 1;
        end
      end
    end
    if (aborted) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 1'b1, 4'hF, 4'hF, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b1));
      exp_status = 2'd2;
      return;
    end
    if (!wr) begin
      for (int k = 0; k < 2*n; k++)
        exp_q.push_back(mk(1'b1, 1'b0, 4'h0, rd[4*k +: 4], 1'b0));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
      exp_rdata = rd & mask;
    end
    exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b1));
  endtask

  // Called #1 after a rising edge with the DUT idle; returns the same way.
  task automatic run(input string name, input logic [3:0] ct, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] sz, input logic [31:0] rd,
                     output int latency);
    build(ct, a, d, sz, rd);
    latency = 0;
    chk($sformatf("%s_ready_idle", name), 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_cyctype_dir = ct; req_addr = a; req_data = d; req_data_size = sz;
    @(posedge lpc_clock); #1;
    // garbage on the request port while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_cyctype_dir = 4'($urandom); req_addr = $urandom; req_data = $urandom;
    req_data_size = 3'($urandom);
    foreach (exp_q[i]) begin
      lpc_ad_in = exp_q[i].din;
      chk($sformatf("%s_c%0d_frame", name, i), 32'(lpc_frame), 32'(exp_q[i].frame));
      chk($sformatf("%s_c%0d_oe", name, i), 32'(lpc_ad_oe), 32'(exp_q[i].oe));
      if (exp_q[i].oe)
        chk($sformatf("%s_c%0d_ad", name, i), 32'(lpc_ad_out), 32'(exp_q[i].ad));
      chk($sformatf("%s_c%0d_respv", name, i), 32'(resp_valid), 32'(exp_q[i].done));
      chk($sformatf("%s_c%0d_ready", name, i), 32'(req_ready), 32'h0);
      if (resp_valid === 1'b1 && latency == 0) latency = i + 1;
      if (exp_q[i].done) begin
        chk($sformatf("%s_rdata", name), resp_data, exp_rdata);
        chk($sformatf("%s_status", name), 32'(resp_status), 32'(exp_status));
      end
      @(posedge lpc_clock); #1;
    end
    req_valid = 1'b0;
    lpc_ad_in = 4'hF;
    chk($sformatf("%s_ready_after", name), 32'(req_ready), 32'h1);
    chk($sformatf("%s_respv_after", name), 32'(resp_valid), 32'h0);
    chk($sformatf("%s_rdata_hold", name), resp_data, exp_rdata);
    chk($sformatf("%s_status_hold", name), 32'(resp_status), 32'(exp_status));
    last_data = exp_rdata;
    last_status = exp_status;
  endtask

  initial begin
    int lat;
    int r;
    logic [3:0] ct;
    logic [2:0] sz;
    logic [3:0] ct_tab [8];
    ct_tab = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h1, 4'h3, 4'h5, 4'h7};

    // Reset values
    #12;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_respv", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_data, 32'h0);
    chk("rst_status", 32'(resp_status), 32'h0);
    chk("rst_frame", 32'(lpc_frame), 32'h1);
    chk("rst_oe", 32'(lpc_ad_oe), 32'h0);
    chk("rst_ad", 32'(lpc_ad_out), 32'hF);
    @(negedge lpc_clock); lpc_reset = 1'b1;
    @(posedge lpc_clock); #1;

    // Memory write, 2 bytes, zero wait states
    sync_q = '{4'h0};
    run("memwr2", 4'b0110, 32'h12347fe5, 32'h0000d569, 3'd2, 32'h0, lat);
    chk("memwr2_latency", 32'(lat), 32'(1+1+1+8+4+2+1+2+1));

    // I/O read with three short waits
    sync_q = '{4'h5, 4'h5, 4'h5, 4'h0};
    run("iord_wait", 4'b0000, 32'h00000080, 32'h0, 3'd1, 32'hc3b2a15a, lat);
    chk("iord_wait_data", resp_data, 32'h0000005a);

    // Latency boundaries
    sync_q = '{4'h0};
    run("iowr1", 4'b0010, 32'h000003f8, 32'h000000a7, 3'd1, 32'h0, lat);
    chk("iowr1_latency", 32'(lat), 32'd14);
    sync_q = '{4'h0};
    run("memrd4", 4'b0100, 32'hfed00040, 32'h0, 3'd4, 32'h89abcdef, lat);
    chk("memrd4_latency", 32'(lat), 32'(1+1+1+8+8+2+1+2+1));

    // No device: 1111 held
    sync_q = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    run("nodev", 4'b0100, 32'h000f0000, 32'h0, 3'd4, 32'h11223344, lat);

    // SYNC error
    sync_q = '{4'hA};
    run("syncerr", 4'b0110, 32'h00001000, 32'h44332211, 3'd4, 32'h0, lat);

    // 32 long waits abort; 31 long waits then ready completes
    sync_q.delete();
    for (int i = 0; i < 34; i++) sync_q.push_back(4'h6);
    run("timeout32", 4'b0010, 32'h00000060, 32'h00000011, 3'd1, 32'h0, lat);
    sync_q.delete();
    for (int i = 0; i < 31; i++) sync_q.push_back(4'h6);
    sync_q.push_back(4'h0);
    run("wait31", 4'b0100, 32'h00002000, 32'h0, 3'd2, 32'h0000beef, lat);

    // No-device counter restarts on other codes; unknown codes count as 1111
    sync_q = '{4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'h0};
    run("nodev_reset", 4'b0000, 32'h00000064, 32'h0, 3'd1, 32'h0000007e, lat);
    sync_q = '{4'h3, 4'h9, 4'hC, 4'h0};
    run("oddcode", 4'b0110, 32'h00003000, 32'h000000aa, 3'd1, 32'h0, lat);

    // Bad requests
    sync_q = '{4'h0};
    run("bad_ct", 4'b1000, 32'h0, 32'h0, 3'd1, 32'h0, lat);
    chk("bad_ct_latency", 32'(lat), 32'h1);
    run("bad_size3", 4'b0100, 32'h0, 32'h0, 3'd3, 32'h0, lat);
    run("bad_io_size2", 4'b0000, 32'h0, 32'h0, 3'd2, 32'h0, lat);

    // Reset in the middle of the address phase
    req_valid = 1'b1; req_cyctype_dir = 4'b0110; req_addr = 32'hdeadbeef;
    req_data = 32'h01020304; req_data_size = 3'd4;
    @(posedge lpc_clock); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge lpc_clock);
    #1;
    chk("midrst_active_oe", 32'(lpc_ad_oe), 32'h1);
    lpc_reset = 1'b0;
    #1;
    chk("midrst_frame", 32'(lpc_frame), 32'h1);
    chk("midrst_oe", 32'(lpc_ad_oe), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    chk("midrst_respv", 32'(resp_valid), 32'h0);
    chk("midrst_status", 32'(resp_status), 32'h0);
    @(negedge lpc_clock); lpc_reset = 1'b1;
    @(posedge lpc_clock); #1;
    sync_q = '{4'h0};
    run("after_rst", 4'b0100, 32'h00c0ffee, 32'h0, 3'd2, 32'h00005a5a, lat);

    // Randomized requests
    for (int t = 0; t < 60; t++) begin
      r  = $urandom_range(0, 9);
      ct = (r < 8) ? ct_tab[r] : 4'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 8) begin
        sz = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : 3'd4;
        if (ct[3:2] == 2'b00 && r < 7) sz = 3'd1;
      end else begin
        sz = 3'($urandom_range(0, 7));
      end
      sync_q.delete();
      for (int w = 0; w < int'($urandom_range(0, 4)); w++)
        sync_q.push_back(($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6);
      if ($urandom_range(0, 3) == 0) begin
        sync_q.push_back(4'hF);
        sync_q.push_back(4'hF);
      end
      r = $urandom_range(0, 9);
      if (r < 7) sync_q.push_back(4'h0);
      else if (r < 9) sync_q.push_back(4'hA);
      else begin
        sync_q.push_back(4'hF); sync_q.push_back(4'hF); sync_q.push_back(4'hF);
      end
      run($sformatf("rnd%0d", t), ct, $urandom, $urandom, sz, $urandom, lat);
    end

    chk("final_ready", 32'(req_ready), 32'h1);
    chk("final_status", 32'(resp_status), 32'(last_status));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
